// File: rtl/stream_mux_pkg.sv
// Shared defaults and arbitration-mode constants for the stream round-robin mux.
package stream_mux_pkg;

  localparam int N_CH_DEF    = 4;
  localparam int W_DEF       = 8;
  localparam int FIXED       = 0;
  localparam int ROUND_ROBIN = 1;

  // Channel-index width, never narrower than one bit.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// One-hot arbiter: packet lock overrides everything, otherwise a wrapped search
// starting at ptr (round-robin) or at channel 0 (fixed priority).
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int  N_CH = N_CH_DEF,
  parameter int  RR   = ROUND_ROBIN,
  localparam int CH_W = ch_width(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [CH_W-1:0] ptr,
  input  logic            lock_en,
  input  logic [CH_W-1:0] lock_idx,
  output logic [N_CH-1:0] grant
);

  logic [CH_W:0]   pos;
  logic [CH_W-1:0] base;
  logic            found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    pos   = '0;
    base  = (RR == ROUND_ROBIN) ? ptr : '0;
    if (lock_en) begin
      grant[lock_idx] = 1'b1;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        // base < N_CH, so one subtraction is enough to wrap
        pos = {1'b0, base} + (CH_W+1)'(k);
        if (pos >= (CH_W+1)'(N_CH)) pos = pos - (CH_W+1)'(N_CH);
        if (!found && req[pos[CH_W-1:0]]) begin
          grant[pos[CH_W-1:0]] = 1'b1;
          found = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream mux with packet locking and a registered output
// stage that sustains one beat per cycle.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int  N_CH = N_CH_DEF,
  parameter int  W    = W_DEF,
  parameter int  RR   = ROUND_ROBIN,
  localparam int CH_W = ch_width(N_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH-1:0]   in_valid,
  output logic [N_CH-1:0]   in_ready,
  input  logic [N_CH*W-1:0] in_data,
  input  logic [N_CH-1:0]   in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      out_data,
  output logic              out_last,
  output logic [CH_W-1:0]   out_ch
);

  logic [N_CH-1:0] grant;
  logic            load;
  logic            xfer;
  logic [W-1:0]    sel_data;
  logic            sel_last;
  logic [CH_W-1:0] sel_idx;
  logic [CH_W-1:0] ptr;
  logic            lock_en;
  logic [CH_W-1:0] lock_idx;

  rr_arbiter #(
    .N_CH (N_CH),
    .RR   (RR)
  ) u_arb (
    .req      (in_valid),
    .ptr      (ptr),
    .lock_en  (lock_en),
    .lock_idx (lock_idx),
    .grant    (grant)
  );

  assign load     = ~out_valid | out_ready;
  // rst_n gates ready so no channel sees a handshake while held in reset
  assign in_ready = grant & {N_CH{load & rst_n}};
  assign xfer     = |(in_valid & in_ready);

  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    sel_idx  = '0;
    for (int i = 0; i < N_CH; i++) begin
      sel_data = sel_data | ({W{grant[i]}} & in_data[i*W +: W]);
      sel_last = sel_last | (grant[i] & in_last[i]);
      sel_idx  = sel_idx  | ({CH_W{grant[i]}} & CH_W'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_ch    <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_last  <= sel_last;
      out_ch    <= sel_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= '0;
      lock_en  <= 1'b0;
      lock_idx <= '0;
    end else if (xfer) begin
      if (sel_last) begin
        ptr     <= (sel_idx == CH_W'(N_CH-1)) ? '0 : sel_idx + CH_W'(1);
        lock_en <= 1'b0;
      end else begin
        lock_en  <= 1'b1;
        lock_idx <= sel_idx;
      end
    end
  end

endmodule

// File: doc/stream_mux_rr.md
STREAM_MUX_RR -- requirements
Module: stream_mux_rr

Interface
REQ-001 Parameter N_CH SHALL be: N_CH, default 4, number of input channels, legal range 2..16.
REQ-002 Parameter W SHALL be: W, default 8, data width per channel, at least 1.
REQ-003 Parameter RR SHALL be: RR, default 1; 1 selects round-robin arbitration, 0 selects fixed priority.
REQ-004 Port clk SHALL be: clk, input, 1, the single clock; every flop samples on its rising edge.
REQ-005 Port rst_n SHALL be: rst_n, input, 1, reset, asynchronous and active-low.
REQ-006 Port in_valid SHALL be: in_valid, input, N_CH, per-channel valid.
REQ-007 Port in_ready SHALL be: in_ready, output, N_CH, per-channel ready.
REQ-008 Port in_data SHALL be: in_data, input, N_CH*W, channel i occupies bits [i*W +: W].
REQ-009 Port in_last SHALL be: in_last, input, N_CH, per-channel end-of-packet flag.
REQ-010 Port out_valid SHALL be: out_valid, output, 1, output register holds a beat.
REQ-011 Port out_ready SHALL be: out_ready, input, 1, downstream accepts the beat.
REQ-012 Port out_data SHALL be: out_data, output, W, registered data.
REQ-013 Port out_last SHALL be: out_last, output, 1, registered last flag.
REQ-014 Port out_ch SHALL be: out_ch, output, CH_W = max(1,$clog2(N_CH)), index of the source channel.

Function
REQ-015 An input transfer SHALL occur on channel i when in_valid[i] & in_ready[i] is high at a clk edge.
REQ-016 An output transfer SHALL occur when out_valid & out_ready is high at a clk edge.
REQ-017 load = ~out_valid | out_ready; in_ready[i] SHALL equal grant[i] & load, combinationally.
REQ-018 At most one grant bit SHALL be high in any cycle, and grant SHALL be all-zero when no in_valid is set.
REQ-019 When not locked and RR=0, grant SHALL go to the lowest-index valid channel.
REQ-020 When not locked and RR=1, grant SHALL go to the first valid channel at or after ptr, searching upward and wrapping from N_CH-1 to 0.
REQ-021 ptr SHALL become (granted index + 1) mod N_CH on every input transfer with in_last=1; ptr SHALL be unchanged otherwise.
REQ-022 An input transfer with in_last=0 SHALL set lock to the granted channel; an input transfer with in_last=1 SHALL clear lock.
REQ-023 While locked, grant SHALL be held on the locked channel only, even if its in_valid is low.
REQ-024 On an input transfer, the selected data, last flag and index SHALL be registered into out_data/out_last/out_ch and out_valid set to 1 at the next edge, giving 1-cycle latency.
REQ-025 An output transfer with no simultaneous input transfer SHALL clear out_valid.
REQ-026 Simultaneous output and input transfers SHALL replace the register contents and keep out_valid=1, sustaining full throughput of one beat per cycle.
REQ-027 While out_valid=1 and out_ready=0, out_data, out_last and out_ch SHALL hold stable.
REQ-028 The data selection SHALL be an AND-OR mux over the one-hot grant, with no priority encoder on the data path.

Reset
REQ-029 While rst_n=0, out_valid, ptr and lock SHALL be 0, and out_data, out_last and out_ch SHALL be 0.
REQ-030 Reset asserted mid-packet SHALL discard the packet state; the first arbitration after release SHALL behave as if ptr=0 and unlocked.

Structure
REQ-031 Package stream_mux_pkg SHALL hold the default values of N_CH and W and the arbitration-mode constants FIXED=0 and ROUND_ROBIN=1.
REQ-032 Arbitration SHALL be implemented in sub-module rr_arbiter, parameterised on N_CH and RR, with inputs req, ptr, lock_en, lock_idx and a one-hot grant output.

Verification
REQ-033 Reset test: N_CH=4, rst_n=0 with all in_valid=1 -> out_valid=0 and in_ready=0000.
REQ-034 Round-robin test: RR=1, all channels valid, in_last=1 on every beat, out_ready=1 -> out_ch sequence 0,1,2,3,0 on consecutive cycles.
REQ-035 Fixed-priority test: RR=0, channels 1 and 3 valid, last=1 on every beat -> out_ch stays 1 while channel 1 remains valid.
REQ-036 Packet-lock test: channel 2 sends 3 beats with last=0,0,1 while channel 0 is valid -> out_ch=2,2,2, then 0; in_ready[0]=0 throughout the packet.
REQ-037 Backpressure test: out_ready=0 for 5 cycles with data 0xA5 held -> out_data=0xA5 stable, in_ready=0000, and no beat lost or duplicated.
REQ-038 Reset-mid-packet test: reset after the first beat of a 3-beat packet on channel 3 -> after release, channel 0 (valid) is granted first.
